// File: rtl/inen_oen_fifo.sv
// Input-enable / output-enable FIFO: Inen pushes data_in, Oen pops the head word onto a registered data_out.
// Optional macro INOEN_FIFO_BYPASS_EN: a push and a pop on an empty FIFO hand data_in straight to data_out.
module inen_oen_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         Inen,
   input  logic                         Oen,
   output logic [WIDTH-1:0]             data_out,
   output logic                         out_valid,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic             wr_en;
   logic             rd_en;
   logic             bypass;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   assign push_ok = Inen & ~full;
   assign pop_ok  = Oen & ~empty;

`ifdef INOEN_FIFO_BYPASS_EN
   // pop_ok is already low when empty, so only the storage write needs suppressing
   assign bypass = empty & Inen & Oen;
`else
   assign bypass = 1'b0;
`endif

   assign wr_en = push_ok & ~bypass;
   assign rd_en = pop_ok;

   // Storage is deliberately left out of reset; stale words are unreachable once count is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else if (bypass) begin
         data_out  <= data_in;
         out_valid <= 1'b1;
      end else if (rd_en) begin
         data_out  <= mem[rd_ptr];
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule
